// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run/step controller: FSM state encoding and the
// default debounce length for the board pushbutton.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } cpu_state_t;

  localparam int unsigned DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Step pushbutton conditioning: 2-FF synchronizer, down-counting debounce
// timer that accepts a new level after DB_CYCLES stable cycles, and a
// registered rising-edge pulse.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned   CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          db_lvl;
  logic          db_prev;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
      press_o <= 1'b0;
      db_cnt  <= RELOAD;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
      db_prev <= db_lvl;
      press_o <= db_lvl & ~db_prev;
      // any return to the accepted level restarts the stability window
      if (sync_q2 == db_lvl) begin
        db_cnt <= RELOAD;
      end else if (db_cnt == '0) begin
        db_lvl <= sync_q2;
        db_cnt <= RELOAD;
      end else begin
        db_cnt <= db_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint controller producing a one-cycle CPU clock enable.
// Breakpoint logic is compiled in only when STEP_BREAKPOINT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_HALT  | idle; run_sw starts RUN, a press issues one STEP
// ST_RUN   | one enable per divider tick until run_sw drops or bp hit
// ST_STEP  | single-cycle state carrying exactly one enable
// ST_BREAK | stopped on breakpoint; press steps over it, run_sw=0 halts
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W     = 24,
  parameter int unsigned FAST_W    = 18,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run_sw,
  input  logic        fast_sw,
  input  logic        step_btn,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_valid,
  output logic        cpu_ce,
  output logic        halted,
  output logic [1:0]  state_o,
  output logic [31:0] step_cnt
);

  cpu_state_t       state;
  cpu_state_t       state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             step_p;
  logic             bp_hit;
  logic             skip_bp;
  logic             skip_set;
  logic             skip_clr;
  logic             run_ce;
  logic             ce_next;

  assign tick = fast_sw ? (&div_cnt[FAST_W-1:0]) : (&div_cnt);

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (step_btn),
    .press_o (step_p)
  );

`ifdef STEP_BREAKPOINT_EN
  // skip_bp lets RUN resume from the instruction it broke on
  always_ff @(posedge clk) begin
    if (!rstn) begin
      skip_bp <= 1'b0;
    end else if (skip_set) begin
      skip_bp <= 1'b1;
    end else if (skip_clr) begin
      skip_bp <= 1'b0;
    end
  end

  assign bp_hit = bp_valid & (pc == bp_addr) & ~skip_bp;
`else
  logic unused_bp;

  assign skip_bp   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid, skip_set, skip_clr, skip_bp};
`endif

  always_comb begin
    state_nx = state;
    skip_set = 1'b0;
    skip_clr = 1'b0;
    run_ce   = 1'b0;
    case (state)
      ST_HALT: begin
        if (run_sw) begin
          state_nx = ST_RUN;
          skip_set = 1'b1;
        end else if (step_p) begin
          state_nx = ST_STEP;
        end
      end
      ST_STEP: state_nx = ST_HALT;
      ST_RUN: begin
        if (!run_sw) begin
          state_nx = ST_HALT;
        end else if (tick && bp_hit) begin
          state_nx = ST_BREAK;
        end else if (tick) begin
          run_ce   = 1'b1;
          skip_clr = 1'b1;
        end
      end
      ST_BREAK: begin
        if (!run_sw) begin
          state_nx = ST_HALT;
        end else if (step_p) begin
          state_nx = ST_STEP;
        end
      end
      default: state_nx = ST_HALT;
    endcase
    ce_next = (state_nx == ST_STEP) | run_ce;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_HALT;
      cpu_ce   <= 1'b0;
      halted   <= 1'b1;
      state_o  <= 2'd0;
      step_cnt <= 32'd0;
      div_cnt  <= '0;
    end else begin
      state    <= state_nx;
      cpu_ce   <= ce_next;
      halted   <= (state_nx == ST_HALT) || (state_nx == ST_BREAK);
      state_o  <= state_nx;
      div_cnt  <= div_cnt + DIV_W'(1);
      if (cpu_ce) begin
        step_cnt <= step_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV_W=6, FAST_W=2, DB_CYCLES=4;
// the breakpoint scenario follows the STEP_BREAKPOINT_EN build setting.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run_sw = 1'b0;
  logic        fast_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        bp_valid = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc;
  logic        cpu_ce;
  logic        halted;
  logic [1:0]  state_o;
  logic [31:0] step_cnt;

  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  cpu_step_ctrl #(
    .DIV_W     (6),
    .FAST_W    (2),
    .DB_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .run_sw   (run_sw),
    .fast_sw  (fast_sw),
    .step_btn (step_btn),
    .pc       (pc),
    .bp_addr  (bp_addr),
    .bp_valid (bp_valid),
    .cpu_ce   (cpu_ce),
    .halted   (halted),
    .state_o  (state_o),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  // CPU model: PC advances by one instruction at the end of each enable cycle
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load_val = v;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    load_pc(32'd0);
    cyc(2);
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %0b expected 0", cpu_ce); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %0b expected 1", halted); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_checks++; if (step_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt); end
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_step;
    int first = -1;
    int pulses = 0;
    logic [1:0] st8 = 2'd0;
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) step_btn = 1'b0;
      if (cpu_ce) begin pulses++; if (first < 0) first = i; end
      if (i == 8) st8 = state_o;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL step_pulses: got %0d expected 1", pulses); end
    n_checks++; if (first != 8) begin n_fail++; $display("FAIL step_latency: got %0d expected 8", first); end
    n_checks++; if (st8 !== 2'd2) begin n_fail++; $display("FAIL step_state: got %0d expected 2", st8); end
    n_checks++; if (step_cnt !== 32'd1) begin n_fail++; $display("FAIL step_cnt1: got %0d expected 1", step_cnt); end
    // bouncing press 1-0-1
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 12) step_btn = 1'b0;
      if (cpu_ce) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    n_checks++; if (step_cnt !== 32'd2) begin n_fail++; $display("FAIL bounce_cnt: got %0d expected 2", step_cnt); end
    cyc(10);
  endtask

  task automatic test_run_rates;
    int last = -1;
    int n = 0;
    int bad = 0;
    int got = 0;
    logic [31:0] cnt_before;
    run_sw = 1'b1;
    fast_sw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ce) begin if (last >= 0 && i - last != 4) bad++; last = i; n++; end
    end
    n_checks++; if (n < 8) begin n_fail++; $display("FAIL fast_count: got %0d expected >=8", n); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fast_spacing: got %0d bad intervals expected 0", bad); end
    fast_sw = 1'b0;
    last = -1; n = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ce) begin if (last >= 0 && i - last != 64) bad++; last = i; n++; end
    end
    n_checks++; if (n < 3) begin n_fail++; $display("FAIL slow_count: got %0d expected >=3", n); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL slow_spacing: got %0d bad intervals expected 0", bad); end
    // drop run_sw exactly in a tick cycle
    fast_sw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ce) begin got = 1; break; end
    end
    n_checks++; if (got != 1) begin n_fail++; $display("FAIL drop_sync: got %0d expected 1 (no pulse within bound)", got); end
    cyc(3);
    run_sw = 1'b0;
    cnt_before = step_cnt;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ce) n++;
    end
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL drop_pulses: got %0d expected 0", n); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL drop_state: got %0d expected 0", state_o); end
    n_checks++; if (step_cnt !== cnt_before) begin n_fail++; $display("FAIL drop_cnt: got %0d expected %0d", step_cnt, cnt_before); end
  endtask

  task automatic test_reset_mid_run;
    run_sw = 1'b1;
    fast_sw = 1'b1;
    cyc(20);
    n_checks++; if (step_cnt == 32'd0) begin n_fail++; $display("FAIL midrun_precnt: got %0d expected nonzero", step_cnt); end
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL midrun_state: got %0d expected 0", state_o); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL midrun_halted: got %0b expected 1", halted); end
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL midrun_ce: got %0b expected 0", cpu_ce); end
    n_checks++; if (step_cnt !== 32'd0) begin n_fail++; $display("FAIL midrun_cnt: got %0d expected 0", step_cnt); end
    run_sw = 1'b0;
    rstn = 1'b1;
    cyc(2);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL midrun_post: got %0d expected 0", state_o); end
  endtask

  task automatic test_precedence;
    logic [31:0] cnt0;
    int last = -1;
    int n = 0;
    int bad = 0;
    fast_sw = 1'b1;
    step_btn = 1'b1;
    cyc(7);
    run_sw = 1'b1;
    cnt0 = step_cnt;
    @(negedge clk);
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL prec_state: got %0d expected 1", state_o); end
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL prec_ce: got %0b expected 0", cpu_ce); end
    n_checks++; if (step_cnt !== cnt0) begin n_fail++; $display("FAIL prec_cnt: got %0d expected %0d", step_cnt, cnt0); end
    step_btn = 1'b0;
    cyc(10);
    step_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_ce) begin if (last >= 0 && i - last != 4) bad++; last = i; n++; end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL run_press_extra: got %0d bad intervals expected 0", bad); end
    n_checks++; if (n < 6) begin n_fail++; $display("FAIL run_press_count: got %0d expected >=6", n); end
    step_btn = 1'b0;
    cyc(10);
    run_sw = 1'b0;
    cyc(3);
  endtask

`ifdef STEP_BREAKPOINT_EN
  task automatic test_breakpoint;
    int got = 0;
    int pulses = 0;
    int saw = 0;
    logic [1:0]  st_ce = 2'd0;
    logic [1:0]  st9 = 2'd0;
    logic [31:0] pc9 = 32'd0;
    rstn = 1'b0;
    run_sw = 1'b0;
    load_pc(32'd0);
    rstn = 1'b1;
    bp_addr = 32'h0000_0010;
    bp_valid = 1'b1;
    fast_sw = 1'b1;
    run_sw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state_o == 2'd3) begin got = 1; break; end
    end
    n_checks++; if (got != 1) begin n_fail++; $display("FAIL bp_reach: got %0d expected 1 (no BREAK within bound)", got); end
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL bp_pc: got %0h expected 10", pc); end
    n_checks++; if (step_cnt !== 32'd4) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 4", step_cnt); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL bp_halted: got %0b expected 1", halted); end
    step_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cpu_ce) begin pulses++; st_ce = state_o; end
      if (i == 9) begin st9 = state_o; pc9 = pc; run_sw = 1'b0; end
    end
    step_btn = 1'b0;
    cyc(10);
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bp_step_pulses: got %0d expected 1", pulses); end
    n_checks++; if (st_ce !== 2'd2) begin n_fail++; $display("FAIL bp_step_state: got %0d expected 2", st_ce); end
    n_checks++; if (st9 !== 2'd0) begin n_fail++; $display("FAIL bp_after_step: got %0d expected 0", st9); end
    n_checks++; if (pc9 !== 32'h14) begin n_fail++; $display("FAIL bp_step_pc: got %0h expected 14", pc9); end
    load_pc(32'h10);
    run_sw = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state_o == 2'd3) saw = 1;
    end
    n_checks++; if (saw != 0) begin n_fail++; $display("FAIL bp_resume_rebreak: got %0d expected 0", saw); end
    n_checks++; if (pc <= 32'h10) begin n_fail++; $display("FAIL bp_resume_pc: got %0h expected >10", pc); end
    run_sw = 1'b0;
    bp_valid = 1'b0;
    cyc(4);
  endtask
`else
  task automatic test_macro_off;
    int saw = 0;
    rstn = 1'b0;
    run_sw = 1'b0;
    load_pc(32'd0);
    rstn = 1'b1;
    bp_addr = 32'h0000_0010;
    bp_valid = 1'b1;
    fast_sw = 1'b1;
    run_sw = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state_o == 2'd3) saw = 1;
    end
    n_checks++; if (saw != 0) begin n_fail++; $display("FAIL nobp_break: got %0d expected 0", saw); end
    n_checks++; if (pc < 32'h14) begin n_fail++; $display("FAIL nobp_pc: got %0h expected >=14", pc); end
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL nobp_state: got %0d expected 1", state_o); end
    run_sw = 1'b0;
    bp_valid = 1'b0;
    cyc(4);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_step();
    test_run_rates();
    test_reset_mid_run();
    test_precedence();
`ifdef STEP_BREAKPOINT_EN
    test_breakpoint();
`else
    test_macro_off();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
